// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared types and constants for the register bus arbiter
package reg_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam logic CSB_IDLE = 1'b1;
  localparam logic WRB_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RDCAP,
    ACK,
    GAP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_id,
  output logic               any
);

  // Pick the set request with the smallest wrap-around distance past 'last'.
  always_comb begin
    int best;
    int d;
    best   = NUM_REQ;
    d      = 0;
    gnt_id = last;
    any    = |req;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j]) begin
        d = (j + 8 * NUM_REQ - int'(last) - 1) % NUM_REQ;
        if (d < best) begin
          best   = d;
          gnt_id = 3'(j);
        end
      end
    end
  end

  // One-hot form of the chosen index, empty when nothing is requesting.
  always_comb begin
    gnt = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      gnt[j] = any && (gnt_id == 3'(j));
    end
  end

endmodule

// File: rtl/reg_bus_arb.sv
// rtl/reg_bus_arb.sv - round-robin sharing of the host register bus between requesters
module reg_bus_arb
  import reg_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GAP_CYC = 0
) (
  input  logic                        Clk_reg,
  input  logic                        Reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        CSB,
  output logic                        WRB,
  output logic [ADDR_W-1:0]           CA,
  output logic [DATA_W-1:0]           CD_wr,
  input  logic [DATA_W-1:0]           CD_rd,
  output logic                        busy,
  output logic [2:0]                  grant_id
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t               state, state_n;
  logic [3:0]           gap_cnt, gap_n;
  logic [2:0]           grant_n;
  logic [NUM_REQ-1:0]   gnt_l, gnt_n;
  logic                 wr_l, wr_n;
  logic                 csb_n, wrb_n, busy_n, arb_ok;
  logic [ADDR_W-1:0]    ca_n;
  logic [DATA_W-1:0]    cd_n, rdata_n;
  logic [NUM_REQ-1:0]   ack_n;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [2:0]           pick_id;
  logic                 pick_any;
  logic                 sel_wr;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req),
    .last   (grant_id),
    .gnt    (pick_oh),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Route the fields of whichever requester the arbiter picked.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick_oh[j]) begin
        sel_wr    = req_wr[j];
        sel_addr  = req_addr[ADDR_W*j +: ADDR_W];
        sel_wdata = req_wdata[DATA_W*j +: DATA_W];
      end
    end
  end

  // State and registered bus/handshake outputs.
  always_ff @(posedge Clk_reg) begin
    if (Reset) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      grant_id <= 3'(NUM_REQ - 1);
      gnt_l    <= '0;
      wr_l     <= 1'b0;
      CSB      <= CSB_IDLE;
      WRB      <= WRB_IDLE;
      CA       <= '0;
      CD_wr    <= '0;
      ack      <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      gap_cnt  <= gap_n;
      grant_id <= grant_n;
      gnt_l    <= gnt_n;
      wr_l     <= wr_n;
      CSB      <= csb_n;
      WRB      <= wrb_n;
      CA       <= ca_n;
      CD_wr    <= cd_n;
      ack      <= ack_n;
      rdata    <= rdata_n;
      busy     <= busy_n;
    end
  end

  // Next state and next output values; outputs are computed one cycle early
  // so that the registered copies line up with the state they belong to.
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    grant_n = grant_id;
    gnt_n   = gnt_l;
    wr_n    = wr_l;
    csb_n   = CSB_IDLE;
    wrb_n   = WRB_IDLE;
    ca_n    = CA;
    cd_n    = CD_wr;
    ack_n   = '0;
    rdata_n = rdata;
    arb_ok  = 1'b0;

    case (state)
      IDLE: arb_ok = 1'b1;
      ISSUE: begin
        if (wr_l) begin
          state_n = ACK;
          ack_n   = gnt_l;
        end else begin
          state_n = RDCAP;
        end
      end
      RDCAP: begin
        rdata_n = CD_rd;
        ack_n   = gnt_l;
        state_n = ACK;
      end
      ACK: begin
        if (GAP_CYC > 0) begin
          state_n = GAP;
          gap_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        // The last gap cycle doubles as the arbitration cycle, so the bus
        // stays idle for exactly the ACK cycle plus GAP_CYC gap cycles.
        if (gap_cnt == GAP_LAST) begin
          gap_n   = '0;
          state_n = IDLE;
          arb_ok  = 1'b1;
        end else begin
          gap_n = gap_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (arb_ok && pick_any) begin
      state_n = ISSUE;
      grant_n = pick_id;
      gnt_n   = pick_oh;
      wr_n    = sel_wr;
      csb_n   = 1'b0;
      wrb_n   = ~sel_wr;
      ca_n    = sel_addr;
      cd_n    = sel_wr ? sel_wdata : '0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_reg_bus_arb.sv
// tb/tb_reg_bus_arb.sv - directed self-checking bench for reg_bus_arb
module tb_reg_bus_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset;
  logic        init_mem;

  logic [1:0]  req_a, req_wr_a, ack_a;
  logic [15:0] req_addr_a;
  logic [31:0] req_wdata_a;
  logic [15:0] rdata_a, cd_wr_a, cd_rd_a;
  logic        csb_a, wrb_a, busy_a;
  logic [7:0]  ca_a;
  logic [2:0]  gid_a;

  logic [1:0]  req_b, req_wr_b, ack_b;
  logic [15:0] req_addr_b;
  logic [31:0] req_wdata_b;
  logic [15:0] rdata_b, cd_wr_b;
  logic [15:0] cd_rd_b;
  logic        csb_b, wrb_b, busy_b;
  logic [7:0]  ca_b;
  logic [2:0]  gid_b;

  logic [15:0] regs [0:127];

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  reg_bus_arb #(.NUM_REQ(2), .GAP_CYC(0)) dut_a (
    .Clk_reg(clk), .Reset(Reset), .req(req_a), .req_wr(req_wr_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a), .ack(ack_a),
    .rdata(rdata_a), .CSB(csb_a), .WRB(wrb_a), .CA(ca_a), .CD_wr(cd_wr_a),
    .CD_rd(cd_rd_a), .busy(busy_a), .grant_id(gid_a)
  );

  reg_bus_arb #(.NUM_REQ(2), .GAP_CYC(3)) dut_b (
    .Clk_reg(clk), .Reset(Reset), .req(req_b), .req_wr(req_wr_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .ack(ack_b),
    .rdata(rdata_b), .CSB(csb_b), .WRB(wrb_b), .CA(ca_b), .CD_wr(cd_wr_b),
    .CD_rd(cd_rd_b), .busy(busy_b), .grant_id(gid_b)
  );

  assign cd_rd_b = 16'h0000;

  // Register file: write on strobe, read data registered one cycle after strobe.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) regs[i] <= 16'h0000;
      regs[7'h03] <= 16'h0002;
      regs[7'h04] <= 16'h000C;
      regs[7'h1A] <= 16'h05FA;
      cd_rd_a     <= 16'h0000;
    end else begin
      if (!csb_a && !wrb_a) regs[ca_a[7:1]] <= cd_wr_a;
      if (!csb_a && wrb_a)  cd_rd_a <= regs[ca_a[7:1]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] acks [$];
    logic       prev_csb;
    int         viol;
    int         s0, s1, n_ack;
    logic [15:0] cd_second;
    logic       busy_gap;

    Reset = 1'b1; init_mem = 1'b1;
    req_a = '0; req_wr_a = '0; req_addr_a = '0; req_wdata_a = '0;
    req_b = '0; req_wr_b = '0; req_addr_b = '0; req_wdata_b = '0;
    tick; tick;
    Reset = 1'b0; init_mem = 1'b0;

    chk("rst_csb", 32'(csb_a), 32'h1);
    chk("rst_wrb", 32'(wrb_a), 32'h1);
    chk("rst_ca", 32'(ca_a), 32'h0);
    chk("rst_cd", 32'(cd_wr_a), 32'h0);
    chk("rst_ack", 32'(ack_a), 32'h0);
    chk("rst_rdata", 32'(rdata_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_gid", 32'(gid_a), 32'h1);

    // Single write from requester 0
    req_a = 2'b01; req_wr_a = 2'b01; req_addr_a[7:0] = 8'h08; req_wdata_a[15:0] = 16'h0005;
    tick;
    chk("wr_csb", 32'(csb_a), 32'h0);
    chk("wr_wrb", 32'(wrb_a), 32'h0);
    chk("wr_ca", 32'(ca_a), 32'h08);
    chk("wr_cd", 32'(cd_wr_a), 32'h0005);
    chk("wr_ack_early", 32'(ack_a), 32'h0);
    chk("wr_gid", 32'(gid_a), 32'h0);
    tick;
    chk("wr_ack", 32'(ack_a), 32'h1);
    chk("wr_csb_ack", 32'(csb_a), 32'h1);
    chk("wr_mem", 32'(regs[4]), 32'h0005);
    req_a = 2'b00;
    tick;
    chk("wr_ack_off", 32'(ack_a), 32'h0);
    chk("wr_idle", 32'(busy_a), 32'h0);

    // Read back IFGset through the bus
    req_a = 2'b01; req_wr_a = 2'b00;
    tick;
    chk("rb_csb", 32'(csb_a), 32'h0);
    chk("rb_wrb", 32'(wrb_a), 32'h1);
    tick;
    chk("rb_rdcap_csb", 32'(csb_a), 32'h1);
    chk("rb_rdcap_ack", 32'(ack_a), 32'h0);
    tick;
    chk("rb_ack", 32'(ack_a), 32'h1);
    chk("rb_rdata", 32'(rdata_a), 32'h0005);
    req_a = 2'b00;
    tick;

    // Single read from requester 1 after reset
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    chk("rst2_gid", 32'(gid_a), 32'h1);
    chk("rst2_rdata", 32'(rdata_a), 32'h0);
    req_a = 2'b10; req_wr_a = 2'b00; req_addr_a[15:8] = 8'h34;
    tick;
    chk("rd1_csb", 32'(csb_a), 32'h0);
    chk("rd1_wrb", 32'(wrb_a), 32'h1);
    chk("rd1_ca", 32'(ca_a), 32'h34);
    chk("rd1_gid", 32'(gid_a), 32'h1);
    tick;
    chk("rd1_rdcap_ack", 32'(ack_a), 32'h0);
    chk("rd1_rdcap_busy", 32'(busy_a), 32'h1);
    tick;
    chk("rd1_ack", 32'(ack_a), 32'h2);
    chk("rd1_rdata", 32'(rdata_a), 32'h05FA);
    req_a = 2'b00;
    tick;
    chk("rd1_ack_off", 32'(ack_a), 32'h0);
    chk("rd1_hold", 32'(rdata_a), 32'h05FA);

    // Reset asserted while a read sits in RDCAP
    req_a = 2'b01; req_wr_a = 2'b00; req_addr_a[7:0] = 8'h06;
    tick;
    tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    chk("mid_csb", 32'(csb_a), 32'h1);
    chk("mid_ack", 32'(ack_a), 32'h0);
    chk("mid_busy", 32'(busy_a), 32'h0);
    chk("mid_rdata", 32'(rdata_a), 32'h0);
    tick;
    chk("mid_reissue", 32'(csb_a), 32'h0);
    tick;
    tick;
    chk("rwr_ack1", 32'(ack_a), 32'h1);
    chk("rwr_rd1", 32'(rdata_a), 32'h0002);
    req_a = 2'b00;
    tick;

    // Write MaxRetry, rdata must hold the previous read
    req_a = 2'b01; req_wr_a = 2'b01; req_wdata_a[15:0] = 16'h0007;
    tick;
    chk("rwr_wr_cd", 32'(cd_wr_a), 32'h0007);
    tick;
    chk("rwr_ack2", 32'(ack_a), 32'h1);
    chk("rwr_hold", 32'(rdata_a), 32'h0002);
    req_a = 2'b00;
    tick;
    req_a = 2'b01; req_wr_a = 2'b00;
    tick; tick; tick;
    chk("rwr_ack3", 32'(ack_a), 32'h1);
    chk("rwr_rd2", 32'(rdata_a), 32'h0007);
    req_a = 2'b00;
    tick;

    // Contention: both requesters held, writes alternate starting at 0
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    req_a = 2'b11; req_wr_a = 2'b11;
    req_addr_a = {8'h12, 8'h10}; req_wdata_a = {16'hBBBB, 16'hAAAA};
    prev_csb = 1'b1; viol = 0;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (ack_a != 2'b00) acks.push_back(ack_a);
      if (!csb_a && !prev_csb) viol++;
      prev_csb = csb_a;
    end
    req_a = 2'b00;
    chk("rr_count", 32'(acks.size()), 32'd4);
    chk("rr_g0", 32'(acks[0]), 32'h1);
    chk("rr_g1", 32'(acks[1]), 32'h2);
    chk("rr_g2", 32'(acks[2]), 32'h1);
    chk("rr_g3", 32'(acks[3]), 32'h2);
    chk("rr_csb_runs", 32'(viol), 32'd0);
    chk("rr_mem0", 32'(regs[8]), 32'hAAAA);
    chk("rr_mem1", 32'(regs[9]), 32'hBBBB);
    tick;

    // GAP_CYC=3: back-to-back writes from requester 0
    req_b = 2'b01; req_wr_b = 2'b01; req_addr_b[7:0] = 8'h20; req_wdata_b[15:0] = 16'h1111;
    s0 = -1; s1 = -1; n_ack = 0; cd_second = 16'h0; busy_gap = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (!csb_b) begin
        if (s0 < 0) s0 = c;
        else if (s1 < 0) begin
          s1 = c;
          cd_second = cd_wr_b;
        end
      end
      if (s0 > 0 && c == s0 + 3) busy_gap = busy_b;
      if (ack_b[0]) begin
        n_ack++;
        if (n_ack == 1) req_wdata_b[15:0] = 16'h2222;
        else req_b = 2'b00;
      end
    end
    chk("gap_idle_cycles", 32'(s1 - s0 - 1), 32'd4);
    chk("gap_acks", 32'(n_ack), 32'd2);
    chk("gap_cd2", 32'(cd_second), 32'h2222);
    chk("gap_busy", 32'(busy_gap), 32'h1);
    chk("gap_end_idle", 32'(busy_b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
